// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Opcodes, sequencer states and IR field positions for ctrl_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  localparam int OPC_W      = 5;
  localparam int REG_FLD_W  = 4;

  localparam int IR_OPC_LSB = 27;
  localparam int IR_RA_LSB  = 23;
  localparam int IR_RB_LSB  = 19;
  localparam int IR_RC_LSB  = 15;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    HALT = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_MULDIV = 3'd1,
    CLS_UNARY  = 3'd2,
    CLS_HALT   = 3'd3,
    CLS_UNDEF  = 3'd4
  } instr_cls_e;

  function automatic instr_cls_e classify(input logic [OPC_W-1:0] opc);
    instr_cls_e cls;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  cls = CLS_ALU;
      OP_MUL, OP_DIV:                   cls = CLS_MULDIV;
      OP_NEG, OP_NOT:                   cls = CLS_UNARY;
      OP_HALT:                          cls = CLS_HALT;
      default:                          cls = CLS_UNDEF;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_select_decode.sv
// ============================================================================
// Module   : reg_select_decode
// Purpose  : Register-field to one-hot enable vector; all zero when disabled.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_select_decode #(
  parameter int NREGS = 16
) (
  input  logic [3:0]       sel_i,
  input  logic             en_i,
  output logic [NREGS-1:0] onehot_o
);

  for (genvar i = 0; i < NREGS; i++) begin : g_bit
    assign onehot_o[i] = en_i && (32'(sel_i) == 32'(i));
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_sequencer.sv
// ============================================================================
// Module   : ctrl_sequencer
// Purpose  : Hardwired T0..T6 fetch/execute sequencer driving datapath strobes.
//            CTRL_ILLEGAL_TRAP_EN: undefined opcodes flag illegal and halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout,
  output logic             pc_out,
  output logic             pc_in,
  output logic             inc_pc,
  output logic             mar_in,
  output logic             mdr_in,
  output logic             mdr_read,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             y_in,
  output logic             zlo_in,
  output logic             zhi_in,
  output logic             zlo_out,
  output logic             zhi_out,
  output logic             lo_in,
  output logic             hi_in,
  output logic [OPW-1:0]   op_code,
  output logic             run,
  output logic             illegal
);

  state_e                 state_q, state_d;
  logic [OPC_W-1:0]       opcode;
  logic [REG_FLD_W-1:0]   ra, rb, rc;
  instr_cls_e             cls;
  logic                   rin_en, rout_en;
  logic [REG_FLD_W-1:0]   rin_sel, rout_sel;
  logic                   illegal_set;
  logic                   unused_ir_low;

  assign opcode        = ir[IR_OPC_LSB +: OPC_W];
  assign ra            = ir[IR_RA_LSB  +: REG_FLD_W];
  assign rb            = ir[IR_RB_LSB  +: REG_FLD_W];
  assign rc            = ir[IR_RC_LSB  +: REG_FLD_W];
  assign cls           = classify(opcode);
  assign unused_ir_low = ^ir[IR_RC_LSB-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= T0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = T0;
    pc_out      = 1'b0;
    pc_in       = 1'b0;
    inc_pc      = 1'b0;
    mar_in      = 1'b0;
    mdr_in      = 1'b0;
    mdr_read    = 1'b0;
    mdr_out     = 1'b0;
    ir_in       = 1'b0;
    y_in        = 1'b0;
    zlo_in      = 1'b0;
    zhi_in      = 1'b0;
    zlo_out     = 1'b0;
    zhi_out     = 1'b0;
    lo_in       = 1'b0;
    hi_in       = 1'b0;
    op_code     = '0;
    rin_en      = 1'b0;
    rin_sel     = ra;
    rout_en     = 1'b0;
    rout_sel    = rb;
    illegal_set = 1'b0;

    case (state_q)
      T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; zlo_in = 1'b1;
        state_d = T1;
      end
      T1: begin
        zlo_out = 1'b1; pc_in = 1'b1; mdr_read = 1'b1; mdr_in = 1'b1;
        state_d = T2;
      end
      T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        state_d = T3;
      end
      T3: begin
        case (cls)
          CLS_ALU: begin
            rout_en = 1'b1; y_in = 1'b1; state_d = T4;
          end
          CLS_MULDIV: begin
            rout_en = 1'b1; rout_sel = ra; y_in = 1'b1; state_d = T4;
          end
          CLS_UNARY: begin
            rout_en = 1'b1; op_code = OPW'(opcode); zlo_in = 1'b1; state_d = T4;
          end
          CLS_HALT: state_d = HALT;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_set = 1'b1;
            state_d     = HALT;
`else
            state_d     = T0;
`endif
          end
        endcase
      end
      T4: begin
        case (cls)
          CLS_ALU: begin
            rout_en = 1'b1; rout_sel = rc; op_code = OPW'(opcode);
            zlo_in = 1'b1; state_d = T5;
          end
          CLS_MULDIV: begin
            rout_en = 1'b1; op_code = OPW'(opcode);
            zlo_in = 1'b1; zhi_in = 1'b1; state_d = T5;
          end
          CLS_UNARY: begin
            zlo_out = 1'b1; rin_en = 1'b1; state_d = T0;
          end
          default: state_d = T0;
        endcase
      end
      T5: begin
        case (cls)
          CLS_ALU: begin
            zlo_out = 1'b1; rin_en = 1'b1; state_d = T0;
          end
          CLS_MULDIV: begin
            zlo_out = 1'b1; lo_in = 1'b1; state_d = T6;
          end
          default: state_d = T0;
        endcase
      end
      T6: begin
        zhi_out = 1'b1; hi_in = 1'b1;
        state_d = T0;
      end
      HALT:    state_d = HALT;
      default: state_d = T0;
    endcase

    // Reset gates outputs combinationally so nothing leaks while it is held.
    if (reset) begin
      pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
      mdr_in = 1'b0; mdr_read = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
      y_in = 1'b0; zlo_in = 1'b0; zhi_in = 1'b0; zlo_out = 1'b0;
      zhi_out = 1'b0; lo_in = 1'b0; hi_in = 1'b0; op_code = '0;
      rin_en = 1'b0; rout_en = 1'b0; illegal_set = 1'b0;
    end
  end

  assign run = !reset && (state_q != HALT);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            illegal_q <= 1'b0;
    else if (illegal_set) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q && !reset;
`else
  logic unused_illegal_set;
  assign unused_illegal_set = illegal_set;
  assign illegal            = 1'b0;
`endif

  reg_select_decode #(.NREGS(NREGS)) u_rin_dec (
    .sel_i    (rin_sel),
    .en_i     (rin_en),
    .onehot_o (rin)
  );

  reg_select_decode #(.NREGS(NREGS)) u_rout_dec (
    .sel_i    (rout_sel),
    .en_i     (rout_en),
    .onehot_o (rout)
  );

endmodule

`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
// ============================================================================
// Module   : tb_ctrl_sequencer
// Purpose  : Directed scoreboard bench for ctrl_sequencer (CTRL_ILLEGAL_TRAP_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ctrl_sequencer;

  localparam logic [14:0] S_PC_OUT   = 15'h0001;
  localparam logic [14:0] S_PC_IN    = 15'h0002;
  localparam logic [14:0] S_INC_PC   = 15'h0004;
  localparam logic [14:0] S_MAR_IN   = 15'h0008;
  localparam logic [14:0] S_MDR_IN   = 15'h0010;
  localparam logic [14:0] S_MDR_RD   = 15'h0020;
  localparam logic [14:0] S_MDR_OUT  = 15'h0040;
  localparam logic [14:0] S_IR_IN    = 15'h0080;
  localparam logic [14:0] S_Y_IN     = 15'h0100;
  localparam logic [14:0] S_ZLO_IN   = 15'h0200;
  localparam logic [14:0] S_ZHI_IN   = 15'h0400;
  localparam logic [14:0] S_ZLO_OUT  = 15'h0800;
  localparam logic [14:0] S_ZHI_OUT  = 15'h1000;
  localparam logic [14:0] S_LO_IN    = 15'h2000;
  localparam logic [14:0] S_HI_IN    = 15'h4000;

  localparam logic [31:0] IR_MUL  = 32'h7B380000;
  localparam logic [31:0] IR_ADD  = 32'h18918000;
  localparam logic [31:0] IR_NEG  = 32'h8A280000;
  localparam logic [31:0] IR_UND  = 32'hF8000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic [15:0] rin, rout;
  logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_read, mdr_out, ir_in;
  logic        y_in, zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in;
  logic [4:0]  op_code;
  logic        run, illegal;

  typedef struct {
    string       tag;
    logic [53:0] v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [14:0] obs_strb;
  logic [53:0] obs;
  assign obs_strb = {hi_in, lo_in, zhi_out, zlo_out, zhi_in, zlo_in, y_in, ir_in,
                     mdr_out, mdr_read, mdr_in, mar_in, inc_pc, pc_in, pc_out};
  assign obs = {rin, rout, obs_strb, op_code, run, illegal};

  always #5 clk = ~clk;

  ctrl_sequencer #(.NREGS(16), .OPW(5)) dut (
    .clk(clk), .reset(reset), .ir(ir),
    .rin(rin), .rout(rout),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc),
    .mar_in(mar_in), .mdr_in(mdr_in), .mdr_read(mdr_read), .mdr_out(mdr_out),
    .ir_in(ir_in), .y_in(y_in),
    .zlo_in(zlo_in), .zhi_in(zhi_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
    .lo_in(lo_in), .hi_in(hi_in),
    .op_code(op_code), .run(run), .illegal(illegal)
  );

  function automatic logic [53:0] ev(input logic [15:0] r_in, input logic [15:0] r_out,
                                     input logic [14:0] s, input logic [4:0] op,
                                     input logic rn, input logic ill);
    return {r_in, r_out, s, op, rn, ill};
  endfunction

  task automatic push(input string tag, input logic [53:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic push_fetch(input string name);
    push({name, "_T0"}, ev(16'h0, 16'h0, S_PC_OUT | S_MAR_IN | S_INC_PC | S_ZLO_IN, 5'd0, 1'b1, 1'b0));
    push({name, "_T1"}, ev(16'h0, 16'h0, S_ZLO_OUT | S_PC_IN | S_MDR_RD | S_MDR_IN, 5'd0, 1'b1, 1'b0));
    push({name, "_T2"}, ev(16'h0, 16'h0, S_MDR_OUT | S_IR_IN, 5'd0, 1'b1, 1'b0));
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_underrun: observed empty queue expected an entry");
    end else begin
      e = q.pop_front();
      n_tests++;
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  // One scoreboard entry per cycle, sampled on the falling edge; the new IR
  // is presented after the T0 check so T3 decodes it.
  task automatic drain(input logic [31:0] irv);
    bit first = 1'b1;
    while (q.size() != 0) begin
      @(negedge clk);
      pop_check();
      if (first) ir = irv;
      first = 1'b0;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic reset_pulse(input string name);
    @(negedge clk);
    reset = 1'b1;
    #1;
    push({name, "_held"}, ev(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b0));
    pop_check();
    release_reset();
  endtask

  initial begin
    reset = 1'b1;
    ir    = 32'h0;

    push("reset_state", ev(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b0));
    push("reset_state2", ev(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b0));
    drain(32'h0);
    release_reset();

    push_fetch("mul");
    push("mul_T3", ev(16'h0, 16'h0040, S_Y_IN, 5'd0, 1'b1, 1'b0));
    push("mul_T4", ev(16'h0, 16'h0080, S_ZLO_IN | S_ZHI_IN, 5'b01111, 1'b1, 1'b0));
    push("mul_T5", ev(16'h0, 16'h0, S_ZLO_OUT | S_LO_IN, 5'd0, 1'b1, 1'b0));
    push("mul_T6", ev(16'h0, 16'h0, S_ZHI_OUT | S_HI_IN, 5'd0, 1'b1, 1'b0));
    drain(IR_MUL);

    push_fetch("add");
    push("add_T3", ev(16'h0, 16'h0004, S_Y_IN, 5'd0, 1'b1, 1'b0));
    push("add_T4", ev(16'h0, 16'h0008, S_ZLO_IN, 5'b00011, 1'b1, 1'b0));
    push("add_T5", ev(16'h0002, 16'h0, S_ZLO_OUT, 5'd0, 1'b1, 1'b0));
    drain(IR_ADD);

    push_fetch("neg");
    push("neg_T3", ev(16'h0, 16'h0020, S_ZLO_IN, 5'b10001, 1'b1, 1'b0));
    push("neg_T4", ev(16'h0010, 16'h0, S_ZLO_OUT, 5'd0, 1'b1, 1'b0));
    drain(IR_NEG);

    push_fetch("undef");
    push("undef_T3", ev(16'h0, 16'h0, 15'h0, 5'd0, 1'b1, 1'b0));
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      push("undef_trap_halt", ev(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b1));
    drain(IR_UND);
    reset_pulse("undef_reset");
`else
    drain(IR_UND);
`endif

    push_fetch("halt");
    push("halt_T3", ev(16'h0, 16'h0, 15'h0, 5'd0, 1'b1, 1'b0));
    for (int i = 0; i < 20; i++)
      push("halt_stay", ev(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b0));
    drain(IR_HALT);
    reset_pulse("halt_reset");

    push_fetch("rst_mul");
    push("rst_mul_T3", ev(16'h0, 16'h0040, S_Y_IN, 5'd0, 1'b1, 1'b0));
    push("rst_mul_T4", ev(16'h0, 16'h0080, S_ZLO_IN | S_ZHI_IN, 5'b01111, 1'b1, 1'b0));
    drain(IR_MUL);

    // Assert reset inside T4: outputs must drop before the next clock edge.
    #1 reset = 1'b1;
    #1;
    push("rst_async", ev(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b0));
    pop_check();
    push("rst_held", ev(16'h0, 16'h0, 15'h0, 5'd0, 1'b0, 1'b0));
    drain(IR_MUL);
    release_reset();

    push_fetch("after_rst");
    push("after_rst_T3", ev(16'h0, 16'h0004, S_Y_IN, 5'd0, 1'b1, 1'b0));
    drain(IR_ADD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
